gf256_log_unit: RTL and testbench

//   Computes the GF(2^8) discrete log: element -> exponent i such that alpha^i = element.
//   It is the inverse of the antilog (exp) ROM, using primitive polynomial x^8+x^4+x^3+x^2+1.

---
 rtl/gf256_pkg.sv | 18 +
 rtl/gf256_log_unit_if.sv | 20 ++
 rtl/gf256_log_ram.sv | 33 +++
 rtl/gf256_log_unit.sv | 151 +++++++++++++++
 tb/tb_gf256_log_unit.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf256_pkg.sv
// Shared GF(2^8) definitions for the gain-control arithmetic path.
package gf256_pkg;

  localparam logic [7:0] GF_POLY_DEFAULT = 8'h1D;
  localparam int         GF_ORDER        = 255;
  localparam logic [7:0] GF_LOG_ZERO     = 8'hFF;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_SERVE = 1'b1
  } log_state_e;

  // Multiply a field element by alpha (x): shift left, reduce by poly when x^8 falls out.
  function automatic logic [7:0] gf_mul_alpha(input logic [7:0] a, input logic [7:0] poly);
    return {a[6:0], 1'b0} ^ (a[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/gf256_log_unit_if.sv
// Request/result stream between a client and the GF(2^8) log unit.
interface gf256_log_unit_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_elem;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_log;
  logic       out_zero;

  modport master (
    output in_valid, in_elem, out_ready,
    input  in_ready, out_valid, out_log, out_zero
  );

  modport slave (
    input  in_valid, in_elem, out_ready,
    output in_ready, out_valid, out_log, out_zero
  );
endinterface

// File: rtl/gf256_log_ram.sv
// 256x8 log table: one write port, one synchronous read port with read enable.
module gf256_log_ram (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem_r [0:255];

  // Table write port, used only while the table is being built.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read; holding re low keeps the last result for backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else if (re) begin
      rdata <= mem_r[raddr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/gf256_log_unit.sv
// GF(2^8) discrete log: builds its own table from the alpha LFSR, then serves lookups.
module gf256_log_unit
  import gf256_pkg::*;
#(
  parameter logic [7:0] POLY = GF_POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  gf256_log_unit_if.slave  bus,
  output logic             init_done,
  output logic             init_err
);

  localparam logic [7:0] LAST_IDX = 8'(GF_ORDER - 1);

  log_state_e state_r, state_nxt_s;
  logic [7:0] idx_r;
  logic [7:0] lfsr_r;
  logic [7:0] lfsr_nxt_s;
  logic       short_cycle_r;
  logic       init_done_r;
  logic       init_err_r;
  logic       out_valid_r;
  logic       zero_r;
  logic       in_ready_s;
  logic       ram_we_s;
  logic       last_step_s;
  logic       accept_s;
  logic       ram_re_s;
  logic [7:0] ram_rdata_s;

  assign lfsr_nxt_s = gf_mul_alpha(lfsr_r, POLY);
  assign accept_s   = bus.in_valid && in_ready_s;
  // Zero never touches the table, so its read is suppressed and the bypass supplies the result.
  assign ram_re_s   = accept_s && (bus.in_elem != 8'h00);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: INIT runs once through the field, SERVE holds until reset.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = ST_SERVE;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_SERVE: state_nxt_s = ST_SERVE;
      default:  state_nxt_s = ST_INIT;
    endcase
  end

  // FSM outputs: table writes during INIT, request acceptance during SERVE.
  always_comb begin
    ram_we_s    = 1'b0;
    in_ready_s  = 1'b0;
    last_step_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        ram_we_s    = 1'b1;
        last_step_s = (idx_r == LAST_IDX);
      end
      ST_SERVE: begin
        in_ready_s = !out_valid_r || bus.out_ready;
      end
      default: begin
        ram_we_s = 1'b0;
      end
    endcase
  end

  // Table-build walk; a primitive poly only revisits 1 on the final step, so an earlier return marks a short cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r         <= 8'h00;
      lfsr_r        <= 8'h01;
      short_cycle_r <= 1'b0;
    end else if (ram_we_s) begin
      idx_r  <= idx_r + 8'd1;
      lfsr_r <= lfsr_nxt_s;
      if ((lfsr_nxt_s == 8'h01) && !last_step_s) begin
        short_cycle_r <= 1'b1;
      end else begin
        short_cycle_r <= short_cycle_r;
      end
    end else begin
      idx_r         <= idx_r;
      lfsr_r        <= lfsr_r;
      short_cycle_r <= short_cycle_r;
    end
  end

  // Build status, latched on the final INIT step and held until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_done_r <= 1'b0;
      init_err_r  <= 1'b0;
    end else if (last_step_s) begin
      init_done_r <= 1'b1;
      init_err_r  <= init_err_r || short_cycle_r || (lfsr_nxt_s != 8'h01);
    end else begin
      init_done_r <= init_done_r;
      init_err_r  <= init_err_r;
    end
  end

  // Result handshake: load on accept, drop on drain, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      zero_r      <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      zero_r      <= (bus.in_elem == 8'h00);
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
      zero_r      <= zero_r;
    end else begin
      out_valid_r <= out_valid_r;
      zero_r      <= zero_r;
    end
  end

  gf256_log_ram u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we_s),
    .waddr (lfsr_r),
    .wdata (idx_r),
    .re    (ram_re_s),
    .raddr (bus.in_elem),
    .rdata (ram_rdata_s)
  );

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_zero  = zero_r;
  assign bus.out_log   = zero_r ? GF_LOG_ZERO : ram_rdata_s;
  assign init_done     = init_done_r;
  assign init_err      = init_err_r;

endmodule

// File: tb/tb_gf256_log_unit.sv
// Scoreboard bench for gf256_log_unit against a field-arithmetic reference model.
module tb_gf256_log_unit;

  logic clk = 1'b0;
  logic rst_n;
  logic init_done, init_err, init_done_b, init_err_b;

  always #5 clk = ~clk;

  gf256_log_unit_if bus();
  gf256_log_unit_if bus_b();

  gf256_log_unit #(.POLY(8'h1D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .init_done(init_done), .init_err(init_err)
  );

  gf256_log_unit #(.POLY(8'h1B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .init_done(init_done_b), .init_err(init_err_b)
  );

  typedef struct {
    logic [7:0] elem;
    logic [7:0] log;
    logic       zero;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   first_xfer = 0;
  int   last_xfer = 0;
  bit   rand_run = 1'b0;

  logic [7:0] exp_tab [0:255];
  logic [7:0] log_tab [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  // Generic GF(2^8) product: carry-less multiply then reduce by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_model();
    logic [7:0] e = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_tab[i] = e;
      log_tab[e] = 8'(i);
      e = gmul(e, 8'h02);
    end
    exp_tab[255] = 8'h00;
    log_tab[0]   = 8'hFF;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] e);
    exp_t x;
    x.elem = e;
    x.zero = (e == 8'h00);
    x.log  = x.zero ? 8'hFF : log_tab[e];
    sb_q.push_back(x);
  endtask

  // Offer one request; returns at posedge+1 after it was accepted.
  task automatic send(input logic [7:0] elem);
    int budget = 0;
    bus.in_valid = 1'b1;
    bus.in_elem  = elem;
    @(negedge clk);
    while (!bus.in_ready && budget < 200) begin
      budget++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stuck 0 for elem %0h", elem);
    end else begin
      push(elem);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count cycles from reset release until init_done; in_ready must stay low throughout.
  task automatic wait_init(input string nm);
    int lo = 0;
    bit seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk);
      if (init_done) seen = 1'b1;
      else begin
        lo++;
        chk({nm, "_in_ready_low"}, 32'(bus.in_ready), 32'd0);
      end
    end
    chk({nm, "_cycles"}, 32'(lo), 32'd255);
  endtask

  // Monitor: every transfer is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got log %0h with nothing outstanding", bus.out_log);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_log", 32'(bus.out_log), 32'(mon_e.log));
        chk("out_zero", 32'(bus.out_zero), 32'(mon_e.zero));
        chk("exp_of_log", 32'(exp_tab[bus.out_log]), 32'(mon_e.elem));
        if (xfer_cnt == 0) first_xfer = cyc;
        last_xfer = cyc;
        xfer_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] dir [0:4];
    logic [7:0] held;
    dir[0] = 8'h02; dir[1] = 8'h1D; dir[2] = 8'h03; dir[3] = 8'h8E; dir[4] = 8'h00;
    build_model();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_elem = 8'h00; bus.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_elem = 8'h00; bus_b.out_ready = 1'b1;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_log", 32'(bus.out_log), 32'd0);
    chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_init_err", 32'(init_err), 32'd0);

    // Build with a request held pending the whole time.
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_elem  = 8'h01;
    wait_init("init");
    chk("serve_in_ready", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) push(8'h01);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("init_err_good_poly", 32'(init_err), 32'd0);
    @(negedge clk);
    chk("latency_first", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

    // Directed lookups, each checked for one-cycle latency.
    for (int i = 0; i < 5; i++) begin
      send(dir[i]);
      @(negedge clk);
      chk("latency_dir", 32'(bus.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    repeat (2) begin @(posedge clk); #1; end

    // Back-to-back stream 1..255 with no bubbles.
    xfer_cnt = 0;
    for (int v = 1; v < 256; v++) send(8'(v));
    repeat (3) begin @(posedge clk); #1; end
    chk("stream_count", 32'(xfer_cnt), 32'd255);
    chk("stream_span", 32'(last_xfer - first_xfer), 32'd254);

    // Backpressure: result held, next request blocked, then drains in order.
    bus.out_ready = 1'b0;
    send(8'h1D);
    bus.in_valid = 1'b1;
    bus.in_elem  = 8'h8E;
    held = log_tab[8'h1D];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_log", 32'(bus.out_log), 32'(held));
      chk("bp_out_zero", 32'(bus.out_zero), 32'd0);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    send(8'h8E);
    repeat (2) begin @(posedge clk); #1; end

    // Random requests with random backpressure.
    rand_run = 1'b1;
    fork
      begin
        while (rand_run) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int n = 0; n < 120; n++) begin
          send(8'($urandom_range(0, 255)));
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        rand_run = 1'b0;
      end
    join
    repeat (4) begin @(posedge clk); #1; end
    chk("sb_drained_rand", 32'(sb_q.size()), 32'd0);

    // Reset pulse while a result is pending.
    bus.out_ready = 1'b0;
    send(8'h03);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_init_done", 32'(init_done), 32'd0);
    bus.out_ready = 1'b1;
    // One cycle since release has already elapsed; 254 more must stay in INIT.
    begin
      int lo = 1;
      bit seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
        @(negedge clk);
        if (init_done) seen = 1'b1;
        else begin
          lo++;
          chk("rebuild_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
      end
      chk("rebuild_cycles", 32'(lo), 32'd255);
    end
    @(posedge clk); #1;
    chk("rebuild_init_err", 32'(init_err), 32'd0);
    for (int n = 0; n < 20; n++) send(8'($urandom_range(0, 255)));
    send(8'h00);
    repeat (3) begin @(posedge clk); #1; end

    // Non-primitive polynomial instance.
    chk("bad_poly_init_done", 32'(init_done_b), 32'd1);
    chk("bad_poly_init_err", 32'(init_err_b), 32'd1);
    chk("sb_empty_end", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
